// File: rtl/wb_la_port_arbiter_if.sv
// Bundle of the WB slave, logic-analyzer and resource-bus signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding SoC and resource.
interface wb_la_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              la_req_i;
    logic              la_we_i;
    logic [ADDR_W-1:0] la_adr_i;
    logic [DATA_W-1:0] la_dat_i;
    logic [DATA_W-1:0] la_dat_o;
    logic              la_done_o;

    logic              res_req_o;
    logic              res_we_o;
    logic [3:0]        res_sel_o;
    logic [ADDR_W-1:0] res_adr_o;
    logic [DATA_W-1:0] res_dat_o;
    logic [DATA_W-1:0] res_dat_i;
    logic              res_ack_i;

    logic              timeout_irq_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  la_req_i, la_we_i, la_adr_i, la_dat_i,
        output la_dat_o, la_done_o,
        output res_req_o, res_we_o, res_sel_o, res_adr_o, res_dat_o,
        input  res_dat_i, res_ack_i,
        output timeout_irq_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output la_req_i, la_we_i, la_adr_i, la_dat_i,
        input  la_dat_o, la_done_o,
        input  res_req_o, res_we_o, res_sel_o, res_adr_o, res_dat_o,
        output res_dat_i, res_ack_i,
        input  timeout_irq_o
    );
endinterface

// File: rtl/wb_la_port_arbiter.sv
// Round-robin share of one resource port between WB and LA; grant->res_req 1 cycle, ack->done 1 cycle.
// Requesters are held off until the single in-flight access completes or times out.
module wb_la_port_arbiter #(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 32,
    parameter logic [7:0]  BASE_HI = 8'h30,
    parameter int          TIMEOUT = 255,
    parameter int          TO_W    = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_la_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic              owner_wb;
    logic              last_wb;
    logic [TO_W-1:0]   cnt;

    logic              wb_req;
    logic              la_req;
    logic              grant_wb;
    logic              timeout_hit;
    logic [DATA_W-1:0] rdata;
    logic              unused_adr;

    assign wb_req      = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == BASE_HI);
    assign la_req      = bus.la_req_i;
    // On contention the requester that did not own the last access wins.
    assign grant_wb    = wb_req & (~la_req | ~last_wb);
    assign timeout_hit = (cnt == TO_W'(TIMEOUT - 1));
    assign rdata       = bus.res_ack_i ? bus.res_dat_i : '1;
    assign unused_adr  = ^{bus.wbs_adr_i[23:ADDR_W+2], bus.wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state             <= IDLE;
            owner_wb          <= 1'b0;
            last_wb           <= 1'b0;
            cnt               <= '0;
            bus.wbs_ack_o     <= 1'b0;
            bus.wbs_dat_o     <= '0;
            bus.la_dat_o      <= '0;
            bus.la_done_o     <= 1'b0;
            bus.res_req_o     <= 1'b0;
            bus.res_we_o      <= 1'b0;
            bus.res_sel_o     <= '0;
            bus.res_adr_o     <= '0;
            bus.res_dat_o     <= '0;
            bus.timeout_irq_o <= 1'b0;
        end else begin
            bus.wbs_ack_o     <= 1'b0;
            bus.la_done_o     <= 1'b0;
            bus.timeout_irq_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_req | la_req) begin
                        owner_wb      <= grant_wb;
                        bus.res_req_o <= 1'b1;
                        cnt           <= '0;
                        state         <= BUSY;
                        if (grant_wb) begin
                            bus.res_we_o  <= bus.wbs_we_i;
                            bus.res_sel_o <= bus.wbs_sel_i;
                            bus.res_adr_o <= bus.wbs_adr_i[ADDR_W+1:2];
                            bus.res_dat_o <= bus.wbs_dat_i;
                        end else begin
                            bus.res_we_o  <= bus.la_we_i;
                            bus.res_sel_o <= 4'hF;
                            bus.res_adr_o <= bus.la_adr_i;
                            bus.res_dat_o <= bus.la_dat_i;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Completion is decided here so ack/done are registered into the DONE cycle;
                    // a requester that has already let go receives nothing.
                    if (bus.res_ack_i || timeout_hit) begin
                        bus.res_req_o     <= 1'b0;
                        bus.timeout_irq_o <= ~bus.res_ack_i;
                        state             <= DONE;
                        if (owner_wb && bus.wbs_cyc_i && bus.wbs_stb_i) begin
                            bus.wbs_ack_o <= 1'b1;
                            bus.wbs_dat_o <= bus.res_we_o ? '0 : rdata;
                        end
                        if (!owner_wb && bus.la_req_i) begin
                            bus.la_done_o <= 1'b1;
                            if (!bus.res_we_o) begin
                                bus.la_dat_o <= rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    last_wb <= owner_wb;
                    cnt     <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_la_port_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_wb_la_port_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_la_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    wb_la_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_HI(8'h30), .TIMEOUT(255), .TO_W(8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus.slave)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [15:0] adr;
        logic [31:0] dat;
    } grant_t;

    grant_t      grant_q[$];
    logic [31:0] wb_exp_q[$];
    logic [31:0] la_exp_q[$];

    int errors = 0;
    int checks = 0;
    int grant_cnt = 0, wb_ack_cnt = 0, la_done_cnt = 0, irq_cnt = 0;
    int req_len = 0, last_req_len = 0;
    logic prev_req = 1'b0;

    // resource responder controls: 0 = ack after ack_delay cycles, 1 = ack tied high, 2 = never
    int          ack_mode = 0;
    int          ack_delay = 0;
    logic        xor_adr = 1'b0;
    logic [31:0] rd_data = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_grant(input logic we, input logic [3:0] sel, input logic [15:0] adr,
                              input logic [31:0] dat);
        grant_t g;
        g.we = we; g.sel = sel; g.adr = adr; g.dat = dat;
        grant_q.push_back(g);
    endtask

    // Monitor
    initial begin
        grant_t g;
        forever begin
            @(negedge clk);
            if (bus.res_req_o) begin
                if (!prev_req) begin
                    grant_cnt++;
                    if (grant_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_grant: got adr 0x%04h, required no grant", bus.res_adr_o);
                    end else begin
                        g = grant_q.pop_front();
                        chk("grant_we",  {31'h0, bus.res_we_o}, {31'h0, g.we});
                        chk("grant_sel", {28'h0, bus.res_sel_o}, {28'h0, g.sel});
                        chk("grant_adr", {16'h0, bus.res_adr_o}, {16'h0, g.adr});
                        chk("grant_dat", bus.res_dat_o, g.dat);
                    end
                end
                req_len++;
            end else if (prev_req) begin
                last_req_len = req_len;
                req_len = 0;
            end
            prev_req = bus.res_req_o;
            if (bus.wbs_ack_o) begin
                wb_ack_cnt++;
                if (wb_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb_ack: got ack data 0x%08h, required no ack", bus.wbs_dat_o);
                end else chk("wb_rdata", bus.wbs_dat_o, wb_exp_q.pop_front());
            end
            if (bus.la_done_o) begin
                la_done_cnt++;
                if (la_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_la_done: got data 0x%08h, required no done", bus.la_dat_o);
                end else chk("la_rdata", bus.la_dat_o, la_exp_q.pop_front());
            end
            if (bus.timeout_irq_o) irq_cnt++;
        end
    end

    // Resource responder
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.res_ack_i = 1'b0;
        bus.res_dat_i = '0;
        forever begin
            @(posedge clk); #1;
            bus.res_dat_i = xor_adr ? (rd_data ^ {16'h0, bus.res_adr_o}) : rd_data;
            if (ack_mode == 2) bus.res_ack_i = 1'b0;
            else if (ack_mode == 1) bus.res_ack_i = 1'b1;
            else if (bus.res_ack_i) begin
                bus.res_ack_i = 1'b0;
                wait_cnt = 0;
            end else if (bus.res_req_o) begin
                if (wait_cnt >= ack_delay) bus.res_ack_i = 1'b1;
                wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int max_cyc, output int lat);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_sel_i = sel;  bus.wbs_dat_i = dat;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus.wbs_ack_o) break;
            if (lat >= max_cyc) begin
                checks++; errors++;
                $display("FAIL wb_ack_wait: got no ack in %0d cycles, required an ack", lat);
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    endtask

    task automatic la_txn(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                          input int max_cyc, output int lat);
        @(posedge clk); #1;
        bus.la_req_i = 1'b1; bus.la_we_i = we; bus.la_adr_i = adr; bus.la_dat_i = dat;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (bus.la_done_o) break;
            if (lat >= max_cyc) begin
                checks++; errors++;
                $display("FAIL la_done_wait: got no done in %0d cycles, required a done", lat);
                break;
            end
        end
        bus.la_req_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat2, g0, a0, i0;
        logic [31:0] la_last;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.la_req_i = 0; bus.la_we_i = 0; bus.la_adr_i = 0; bus.la_dat_i = 0;
        la_last = 32'h0;

        // reset values
        idle_cycles(2);
        chk("reset_ctrl", {25'h0, bus.wbs_ack_o, bus.la_done_o, bus.res_req_o, bus.res_we_o,
                           bus.timeout_irq_o, bus.res_sel_o == 4'h0, 1'b0}, 32'h2);
        chk("reset_wbs_dat", bus.wbs_dat_o, 32'h0);
        chk("reset_la_dat", bus.la_dat_o, 32'h0);
        chk("reset_res_adr_dat", {16'h0, bus.res_adr_o} | bus.res_dat_o, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // WB read, ack one cycle after res_req_o
        ack_mode = 0; ack_delay = 1; rd_data = 32'hCAFE_F00D;
        push_grant(1'b0, 4'hF, 16'h0004, 32'h1111_2222);
        wb_exp_q.push_back(32'hCAFE_F00D);
        wb_txn(1'b0, 32'h3000_0010, 4'hF, 32'h1111_2222, 20, lat);
        chk("wb_read_latency", lat, 3);
        idle_cycles(1);
        chk("wb_ack_single_pulse", {31'h0, bus.wbs_ack_o}, 32'h0);
        chk("wb_read_req_len", last_req_len, 2);

        // WB write with partial byte selects: data returned as 0
        ack_delay = 2;
        push_grant(1'b1, 4'b0011, 16'h0040, 32'hDEAD_BEEF);
        wb_exp_q.push_back(32'h0);
        wb_txn(1'b1, 32'h3000_0100, 4'b0011, 32'hDEAD_BEEF, 20, lat);
        chk("wb_write_latency", lat, 4);

        // LA read, immediate ack
        ack_delay = 0; rd_data = 32'h1234_5678;
        push_grant(1'b0, 4'hF, 16'h0040, 32'h0);
        la_last = 32'h1234_5678;
        la_exp_q.push_back(la_last);
        la_txn(1'b0, 16'h0040, 32'h0, 20, lat);
        chk("la_read_latency", lat, 2);

        // LA write with ack tied high: la_dat_o keeps the previous read data
        ack_mode = 1;
        push_grant(1'b1, 4'hF, 16'h0123, 32'h55AA_55AA);
        la_exp_q.push_back(la_last);
        la_txn(1'b1, 16'h0123, 32'h55AA_55AA, 20, lat);
        chk("la_write_latency", lat, 2);
        ack_mode = 0;
        idle_cycles(2);

        // Simultaneous requests, four rounds: WB then LA each round
        xor_adr = 1'b1; rd_data = 32'hA5A5_0000;
        for (int r = 0; r < 4; r++) begin
            push_grant(1'b0, 4'hF, 16'h0040 + 16'(4*r), 32'h0);
            push_grant(1'b0, 4'hF, 16'h0200 + 16'(r), 32'h0);
            wb_exp_q.push_back(32'hA5A5_0000 ^ (32'h40 + 32'(4*r)));
            la_exp_q.push_back(32'hA5A5_0000 ^ (32'h200 + 32'(r)));
            fork
                wb_txn(1'b0, 32'h3000_0100 + 32'(16*r), 4'hF, 32'h0, 30, lat);
                la_txn(1'b0, 16'h0200 + 16'(r), 32'h0, 30, lat2);
            join
            chk("rr_wb_first_latency", lat, 2);
            chk("rr_la_second_latency", lat2, 5);
        end

        // WB alone, then contention: LA must win since WB owned the last access
        push_grant(1'b0, 4'hF, 16'h0001, 32'h0);
        wb_exp_q.push_back(32'hA5A5_0001);
        wb_txn(1'b0, 32'h3000_0004, 4'hF, 32'h0, 20, lat);
        push_grant(1'b0, 4'hF, 16'h0300, 32'h0);
        push_grant(1'b0, 4'hF, 16'h0002, 32'h0);
        la_exp_q.push_back(32'hA5A5_0300);
        wb_exp_q.push_back(32'hA5A5_0002);
        fork
            wb_txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, 30, lat);
            la_txn(1'b0, 16'h0300, 32'h0, 30, lat2);
        join
        chk("rr_la_wins_latency", lat2, 2);
        chk("rr_wb_waits_latency", lat, 5);
        la_last = 32'hA5A5_0300;
        xor_adr = 1'b0;

        // Address outside BASE_HI window: never granted
        g0 = grant_cnt;
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h2000_0000;
        idle_cycles(6);
        chk("bad_addr_no_req", {31'h0, bus.res_req_o}, 32'h0);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        idle_cycles(1);
        chk("bad_addr_no_grant", grant_cnt, g0);

        // Abort: stb drops mid-access, resource access still finishes, no ack
        ack_delay = 5; a0 = wb_ack_cnt;
        push_grant(1'b0, 4'hF, 16'h0008, 32'h0);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = 32'h3000_0020; bus.wbs_dat_i = 0;
        idle_cycles(2);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        idle_cycles(10);
        chk("abort_req_len", last_req_len, 6);
        chk("abort_no_ack", wb_ack_cnt, a0);

        // Timeout: res_req_o held exactly 255 cycles, one IRQ pulse, all-ones data
        ack_mode = 2; i0 = irq_cnt;
        push_grant(1'b0, 4'hF, 16'h0010, 32'h0);
        wb_exp_q.push_back(32'hFFFF_FFFF);
        wb_txn(1'b0, 32'h3000_0040, 4'hF, 32'h0, 400, lat);
        chk("timeout_latency", lat, 256);
        idle_cycles(2);
        chk("timeout_req_len", last_req_len, 255);
        chk("timeout_irq_pulses", irq_cnt, i0 + 1);

        // Reset while BUSY: outputs clear immediately, then normal service resumes
        i0 = irq_cnt; a0 = wb_ack_cnt;
        push_grant(1'b0, 4'hF, 16'h0020, 32'h0);
        @(posedge clk); #1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_adr_i = 32'h3000_0080;
        idle_cycles(3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_res_req", {31'h0, bus.res_req_o}, 32'h0);
        chk("midrst_res_adr", {16'h0, bus.res_adr_o}, 32'h0);
        chk("midrst_wbs_dat", bus.wbs_dat_o, 32'h0);
        chk("midrst_la_dat", bus.la_dat_o, 32'h0);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        idle_cycles(3);
        rst = 1'b0;
        ack_mode = 0; ack_delay = 0; rd_data = 32'h0BAD_F00D;
        idle_cycles(1);
        chk("midrst_no_irq", irq_cnt, i0);
        chk("midrst_no_ack", wb_ack_cnt, a0);
        push_grant(1'b0, 4'hF, 16'h0001, 32'h0);
        wb_exp_q.push_back(32'h0BAD_F00D);
        wb_txn(1'b0, 32'h3000_0004, 4'hF, 32'h0, 20, lat);
        chk("post_rst_latency", lat, 2);

        idle_cycles(4);
        chk("grant_q_drained", grant_q.size(), 0);
        chk("wb_q_drained", wb_exp_q.size(), 0);
        chk("la_q_drained", la_exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
